// File: rtl/mac_dot_sequencer_if.sv
// Handshake and MAC-side signal bundle for the dot-product sequencer.
// slave is the sequencer's view; master is the view of the surrounding
// source, consumer and MAC.
interface mac_dot_sequencer_if #(
    parameter int LEN_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_result;
    logic             out_overflow;
    logic [3:0]       mac_operand_a;
    logic [3:0]       mac_operand_b;
    logic             mac_reset;
    logic [7:0]       mac_result;

    modport slave (
        input  cmd_valid, cmd_len, in_valid, in_a, in_b, out_ready, mac_result,
        output cmd_ready, in_ready, out_valid, out_result, out_overflow,
               mac_operand_a, mac_operand_b, mac_reset
    );

    modport master (
        output cmd_valid, cmd_len, in_valid, in_a, in_b, out_ready, mac_result,
        input  cmd_ready, in_ready, out_valid, out_result, out_overflow,
               mac_operand_a, mac_operand_b, mac_reset
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer: takes a length command, clears an external 4x4 MAC,
// streams operand pairs into it and presents the 8-bit accumulated sum with a
// sticky overflow flag on a valid/ready output.
module mac_dot_sequencer #(
    parameter int MAX_LEN = 15,
    parameter int LEN_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    mac_dot_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [7:0]       out_result_q;
    logic             out_overflow_q;
    logic             cmd_ready_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             clr_q;
    logic             fire;

    // Commands longer than the engine supports are truncated to MAX_LEN.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (int'(len) > MAX_LEN) begin
            return LEN_W'(MAX_LEN);
        end
        return len;
    endfunction

    // True when adding a*b to the accumulator carries past 8 bits.
    function automatic logic sum_overflows(input logic [7:0] acc,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
        logic [7:0] prod;
        logic [8:0] sum;
        prod = {4'd0, a} * {4'd0, b};
        sum  = {1'b0, acc} + {1'b0, prod};
        return sum[8];
    endfunction

    assign fire  = bus.in_valid & in_ready_q;
    assign cnt_d = cnt_q + LEN_W'(1);

    // Operands are zero unless a pair is actually being transferred, so the
    // free-running MAC only accumulates accepted data.
    assign bus.mac_operand_a = fire ? bus.in_a : 4'd0;
    assign bus.mac_operand_b = fire ? bus.in_b : 4'd0;
    assign bus.mac_reset     = reset | clr_q;
    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_result    = out_result_q;
    assign bus.out_overflow  = out_overflow_q;

    // Sticky overflow update for the pair accepted this cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (fire && sum_overflows(bus.mac_result, bus.in_a, bus.in_b)) begin
            ovf_d = 1'b1;
        end
    end

    // Command FSM; handshake outputs are registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            len_q          <= '0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            out_result_q   <= 8'd0;
            out_overflow_q <= 1'b0;
            cmd_ready_q    <= 1'b1;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            clr_q          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        len_q       <= clamp_len(bus.cmd_len);
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        clr_q       <= 1'b1;
                        state_q     <= CLEAR;
                    end
                end
                CLEAR: begin
                    clr_q <= 1'b0;
                    if (len_q == '0) begin
                        state_q <= DRAIN;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (fire) begin
                        ovf_q <= ovf_d;
                        cnt_q <= cnt_d;
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            in_ready_q <= 1'b0;
                            state_q    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The last pair's product has landed in the MAC by now.
                    out_result_q   <= bus.mac_result;
                    out_overflow_q <= ovf_q;
                    out_valid_q    <= 1'b1;
                    state_q        <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    clr_q       <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a behavioural MAC and a result
// scoreboard.
module tb_mac_dot_sequencer;
    localparam int LEN_W = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mac_dot_sequencer_if #(.LEN_W(LEN_W)) bus ();

    mac_dot_sequencer #(.MAX_LEN(15), .LEN_W(LEN_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural 4x4 MAC with synchronous clear.
    logic [7:0] mac_acc;
    always @(posedge clock) begin
        if (bus.mac_reset) mac_acc <= 8'd0;
        else mac_acc <= mac_acc + ({4'd0, bus.mac_operand_a} * {4'd0, bus.mac_operand_b});
    end
    assign bus.mac_result = mac_acc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] exp_res_q[$];
    logic       exp_ovf_q[$];
    logic [3:0] pa[16];
    logic [3:0] pb[16];

    task automatic tick;
        @(negedge clock);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one command, feed its pairs (gap idle cycles between pairs), hold
    // out_ready low for 'hold' cycles in DONE, then check the scoreboard.
    task automatic run_cmd(input int len, input int gap, input int hold);
        int n, sum, e_cyc, waited;
        logic [7:0] held, er;
        logic eo;
        n = (len > 15) ? 15 : len;
        sum = 0;
        for (int i = 0; i < n; i++) sum += int'(pa[i]) * int'(pb[i]);
        exp_res_q.push_back(8'(sum));
        exp_ovf_q.push_back(sum > 255);

        chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_W'(len);
        tick;
        e_cyc = cyc;
        bus.cmd_valid = 1'b0;
        #1;
        chk("clear_mac_reset", 32'(bus.mac_reset), 32'd1);
        chk("clear_in_ready", 32'(bus.in_ready), 32'd0);
        chk("clear_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        tick;

        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus.in_valid = 1'b0;
                    #1;
                    chk("bubble_in_ready", 32'(bus.in_ready), 32'd1);
                    chk("bubble_op_a", 32'(bus.mac_operand_a), 32'd0);
                    tick;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_a     = pa[i];
            bus.in_b     = pb[i];
            waited = 0;
            #1;
            while (!bus.in_ready && waited < 20) begin
                tick;
                #1;
                waited++;
            end
            chk("pair_accepted", 32'(bus.in_ready), 32'd1);
            chk("op_a_pass", 32'(bus.mac_operand_a), 32'(pa[i]));
            chk("op_b_pass", 32'(bus.mac_operand_b), 32'(pb[i]));
            tick;
        end
        bus.in_valid = 1'b0;
        bus.in_a     = 4'hF;
        bus.in_b     = 4'hF;

        waited = 0;
        #1;
        while (!bus.out_valid && waited < 40) begin
            chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
            chk("idle_op_a", 32'(bus.mac_operand_a), 32'd0);
            tick;
            #1;
            waited++;
        end
        chk("out_valid_seen", 32'(bus.out_valid), 32'd1);
        if (gap == 0) chk("latency", 32'(cyc - e_cyc), 32'(n + 2));

        held = bus.out_result;
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            tick;
            #1;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_stable", 32'(bus.out_result), 32'(held));
            chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end

        bus.out_ready = 1'b1;
        er = exp_res_q.pop_front();
        eo = exp_ovf_q.pop_front();
        chk("result", 32'(bus.out_result), 32'(er));
        chk("overflow", 32'(bus.out_overflow), 32'(eo));
        tick;
        bus.out_ready = 1'b0;
        #1;
        chk("out_valid_cleared", 32'(bus.out_valid), 32'd0);
        chk("cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 4'd0;
        bus.in_b      = 4'd0;
        bus.out_ready = 1'b0;
        tick;
        tick;
        #1;
        chk("rst_mac_reset", 32'(bus.mac_reset), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_op_a", 32'(bus.mac_operand_a), 32'd0);
        chk("rst_op_b", 32'(bus.mac_operand_b), 32'd0);
        chk("rst_result", 32'(bus.out_result), 32'd0);
        chk("rst_overflow", 32'(bus.out_overflow), 32'd0);
        reset = 1'b0;
        tick;
        #1;
        chk("post_rst_mac_reset", 32'(bus.mac_reset), 32'd0);

        // len=3, no bubbles: 10+143+1 = 154
        pa[0] = 4'd5;  pb[0] = 4'd2;
        pa[1] = 4'd13; pb[1] = 4'd11;
        pa[2] = 4'd1;  pb[2] = 4'd1;
        run_cmd(3, 0, 0);

        // len=2 saturating products: 450 mod 256 = 194, overflow
        pa[0] = 4'd15; pb[0] = 4'd15;
        pa[1] = 4'd15; pb[1] = 4'd15;
        run_cmd(2, 0, 0);

        // len=0: empty product, overflow from previous command cleared
        run_cmd(0, 0, 0);

        // len=3 with bubbles and a stalled consumer
        pa[0] = 4'd5;  pb[0] = 4'd2;
        pa[1] = 4'd13; pb[1] = 4'd11;
        pa[2] = 4'd1;  pb[2] = 4'd1;
        run_cmd(3, 2, 4);

        // back-to-back single-pair commands
        pa[0] = 4'd15; pb[0] = 4'd15;
        run_cmd(1, 0, 0);
        pa[0] = 4'd2;  pb[0] = 4'd3;
        run_cmd(1, 0, 0);

        // abort a len=3 command after one pair
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_W'(3);
        tick;
        bus.cmd_valid = 1'b0;
        tick;
        bus.in_valid = 1'b1;
        bus.in_a     = 4'd7;
        bus.in_b     = 4'd9;
        tick;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_mac_reset", 32'(bus.mac_reset), 32'd1);
        tick;
        reset = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
        tick;
        #1;
        chk("abort_stays_idle", 32'(bus.out_valid), 32'd0);

        pa[0] = 4'd4; pb[0] = 4'd4;
        run_cmd(1, 0, 0);

        chk("scoreboard_empty", 32'(exp_res_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
